// File: rtl/ptw_read_arbiter.sv
// Page-table-walk read arbiter: merges ITLB and DTLB PTE reads onto a single AR/R channel.
// One transaction is outstanding at a time, contention is resolved round-robin.
module ptw_read_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_err,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_resp_valid,
    input  logic                  d_resp_ready,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    input  logic                  m_r_valid,
    output logic                  m_r_ready,
    input  logic [DATA_WIDTH-1:0] m_r_data,
    input  logic [1:0]            m_r_resp
);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int TCNT_W     = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TLAST_I    = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TLAST_I);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  drop_q, drop_d;
    logic                  orphan_q, orphan_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  i_rv_q, i_rv_d;
    logic                  d_rv_q, d_rv_d;
    logic                  grant_i, grant_d;
    logic                  owner_resp_ready;

    assign owner_resp_ready = (owner_q == OWN_D) ? d_resp_ready : i_resp_ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        orphan_d     = orphan_q;
        addr_d       = addr_q;
        data_d       = data_q;
        err_d        = err_q;
        tcnt_d       = tcnt_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Ties go to whichever master was not served last.
                if (!flush && !rst) begin
                    if (i_req_valid && (!d_req_valid || last_grant_q == OWN_D)) begin
                        grant_i = 1'b1;
                    end else if (d_req_valid) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_i || grant_d) begin
                    state_d      = S_ADDR;
                    owner_d      = grant_d;
                    last_grant_d = grant_d;
                    addr_d       = grant_d ? d_req_addr : i_req_addr;
                    drop_d       = 1'b0;
                    orphan_d     = 1'b0;
                end
            end
            S_ADDR: begin
                drop_d = drop_q | flush;
                if (m_ar_ready) begin
                    state_d = S_DATA;
                    tcnt_d  = '0;
                end
            end
            S_DATA: begin
                drop_d = drop_q | flush;
                if (m_r_valid) begin
                    if (drop_d) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = m_r_data;
                        err_d   = (m_r_resp != 2'b00);
                        state_d = S_RESP;
                    end
                end else if (TIMEOUT_EN && tcnt_q == TCNT_LAST) begin
                    // The late beat is still owed by memory; DRAIN swallows it afterwards.
                    orphan_d = 1'b1;
                    if (drop_d) begin
                        state_d = S_DRAIN;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (TIMEOUT_EN && tcnt_q != TCNT_MAX) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_RESP: begin
                if (owner_resp_ready || flush) begin
                    state_d = orphan_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (m_r_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ar_valid_d = (state_d == S_ADDR);
        r_ready_d  = (state_d == S_DATA) || (state_d == S_DRAIN);
        i_rv_d     = (state_d == S_RESP) && (owner_d == OWN_I);
        d_rv_d     = (state_d == S_RESP) && (owner_d == OWN_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            drop_q       <= 1'b0;
            orphan_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            tcnt_q       <= '0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            i_rv_q       <= 1'b0;
            d_rv_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            orphan_q     <= orphan_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            tcnt_q       <= tcnt_d;
            ar_valid_q   <= ar_valid_d;
            r_ready_q    <= r_ready_d;
            i_rv_q       <= i_rv_d;
            d_rv_q       <= d_rv_d;
        end
    end

    assign i_req_ready  = grant_i;
    assign d_req_ready  = grant_d;
    assign m_ar_valid   = ar_valid_q;
    assign m_ar_addr    = addr_q;
    assign m_r_ready    = r_ready_q;
    assign i_resp_valid = i_rv_q;
    assign d_resp_valid = d_rv_q;
    assign i_resp_data  = data_q;
    assign d_resp_data  = data_q;
    assign i_resp_err   = err_q;
    assign d_resp_err   = err_q;

endmodule

// File: tb/tb_ptw_read_arbiter.sv
// Bench for ptw_read_arbiter: vector table, directed corner sequences and randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_ptw_read_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam logic [63:0] KEY = 64'hC3C3_5A5A_0F0F_F0F0;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_err;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid, d_req_ready, d_resp_valid, d_resp_ready, d_resp_err;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_resp_data;
    logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [AW-1:0] m_ar_addr;
    logic [DW-1:0] m_r_data;
    logic [1:0]    m_r_resp;

    int unsigned total = 0;
    int unsigned passed = 0;

    typedef struct packed {
        logic        use_d;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs [6];

    // transaction-level model state for the randomized phase
    bit          m_busy, m_lastd, m_cur_d, m_ar_pend, m_r_wait, m_rv, i_want, d_want, gi, gd;
    logic [63:0] m_cur_addr, mem_addr, ia, da;
    int unsigned beat_dly;

    always #5 clk = ~clk;

    ptw_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
        .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_i_req_ready"}, i_req_ready, 1'b0);
        chk1({tag, "_d_req_ready"}, d_req_ready, 1'b0);
        chk1({tag, "_ar_valid"}, m_ar_valid, 1'b0);
        chk64({tag, "_ar_addr"}, m_ar_addr, 64'h0);
        chk1({tag, "_r_ready"}, m_r_ready, 1'b0);
        chk1({tag, "_i_resp_valid"}, i_resp_valid, 1'b0);
        chk1({tag, "_d_resp_valid"}, d_resp_valid, 1'b0);
        chk64({tag, "_i_resp_data"}, i_resp_data, 64'h0);
        chk64({tag, "_d_resp_data"}, d_resp_data, 64'h0);
        chk1({tag, "_i_resp_err"}, i_resp_err, 1'b0);
        chk1({tag, "_d_resp_err"}, d_resp_err, 1'b0);
    endtask

    // Full zero-wait transaction with latency checks; optionally the other master contends.
    task automatic run_txn(input logic use_d, input logic both, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [1:0] rresp,
                           input logic [63:0] exp_data, input logic exp_err);
        i_req_valid = !use_d || both;
        d_req_valid = use_d || both;
        i_req_addr  = use_d ? ~addr : addr;
        d_req_addr  = use_d ? addr : ~addr;
        #1;
        chk1("grant_i", i_req_ready, !use_d);
        chk1("grant_d", d_req_ready, use_d);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        i_req_addr  = 64'h0;
        d_req_addr  = 64'h0;
        #1;
        chk1("ar_valid_t1", m_ar_valid, 1'b1);
        chk64("ar_addr_t1", m_ar_addr, addr);
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        m_r_data   = rdata;
        m_r_resp   = rresp;
        #1;
        chk1("r_ready_t2", m_r_ready, 1'b1);
        chk1("ar_valid_t2", m_ar_valid, 1'b0);
        chk1("resp_early", i_resp_valid | d_resp_valid, 1'b0);
        tick();
        m_r_valid = 1'b0;
        m_r_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        m_r_resp  = 2'b00;
        #1;
        chk1("resp_valid_owner", use_d ? d_resp_valid : i_resp_valid, 1'b1);
        chk1("resp_valid_other", use_d ? i_resp_valid : d_resp_valid, 1'b0);
        chk64("resp_data", use_d ? d_resp_data : i_resp_data, exp_data);
        chk1("resp_err", use_d ? d_resp_err : i_resp_err, exp_err);
        if (use_d) d_resp_ready = 1'b1;
        else i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        d_resp_ready = 1'b0;
        #1;
        chk1("resp_done", i_resp_valid | d_resp_valid, 1'b0);
    endtask

    // Issue a request and complete the AR handshake; returns in the first DATA cycle.
    task automatic to_data(input logic use_d, input logic [63:0] addr);
        i_req_valid = !use_d;
        d_req_valid = use_d;
        i_req_addr  = addr;
        d_req_addr  = addr;
        #1;
        chk1("to_data_grant", use_d ? d_req_ready : i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        m_ar_ready  = 1'b1;
        tick();
        m_ar_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 64'h0000_0000_8000_1000, 64'h0000_0000_2000_04CF, 2'b00, 64'h0000_0000_2000_04CF, 1'b0};
        vecs[1] = '{1'b1, 64'h0000_0000_8000_2008, 64'h0000_0000_3000_0001, 2'b00, 64'h0000_0000_3000_0001, 1'b0};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 2'b11, 64'h0000_0000_0000_0000, 1'b1};
        vecs[4] = '{1'b1, 64'h1234_5678_9ABC_DEF0, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1};
        vecs[5] = '{1'b0, 64'h0000_0000_0000_4000, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF, 1'b0};

        rst = 1'b1; flush = 1'b0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        i_req_addr = 64'h1111; d_req_addr = 64'h2222;
        i_resp_ready = 1'b0; d_resp_ready = 1'b0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_data = 64'h0; m_r_resp = 2'b00;
        tick();
        tick();
        #1;
        chk_all_zero("reset");
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        rst = 1'b0;
        tick();

        // simultaneous requests after reset: I first, then strict alternation
        for (int k = 0; k < 16; k++) begin
            run_txn(k[0], 1'b1, 64'h8000_0000 + 64'(k) * 8, 64'h1000 + 64'(k), 2'b00,
                    64'h1000 + 64'(k), 1'b0);
        end

        for (int k = 0; k < 6; k++) begin
            run_txn(vecs[k].use_d, 1'b0, vecs[k].addr, vecs[k].rdata, vecs[k].rresp,
                    vecs[k].exp_data, vecs[k].exp_err);
        end

        // AR stalled for 20 cycles: address held, no timeout outside DATA
        i_req_valid = 1'b1;
        i_req_addr  = 64'h8000_4000;
        #1;
        chk1("stall_grant", i_req_ready, 1'b1);
        tick();
        i_req_valid = 1'b0;
        i_req_addr  = 64'hDEAD_DEAD_DEAD_DEAD;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk1("stall_ar_valid", m_ar_valid, 1'b1);
            chk64("stall_ar_addr", m_ar_addr, 64'h8000_4000);
            tick();
        end
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1; m_r_data = 64'h2000_0401; m_r_resp = 2'b00;
        tick();
        m_r_valid = 1'b0;
        #1;
        chk1("stall_resp_valid", i_resp_valid, 1'b1);
        chk64("stall_resp_data", i_resp_data, 64'h2000_0401);
        chk1("stall_resp_err", i_resp_err, 1'b0);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;

        // timeout after TO DATA cycles, late beat sunk in DRAIN
        to_data(1'b1, 64'h8000_5000);
        for (int k = 0; k < TO; k++) begin
            #1;
            chk1("to_wait_resp", d_resp_valid, 1'b0);
            chk1("to_wait_r_ready", m_r_ready, 1'b1);
            tick();
        end
        #1;
        chk1("to_resp_valid", d_resp_valid, 1'b1);
        chk64("to_resp_data", d_resp_data, 64'h0);
        chk1("to_resp_err", d_resp_err, 1'b1);
        d_resp_ready = 1'b1;
        tick();
        d_resp_ready = 1'b0;
        #1;
        chk1("drain_r_ready", m_r_ready, 1'b1);
        chk1("drain_no_resp", d_resp_valid, 1'b0);
        m_r_valid = 1'b1; m_r_data = 64'h1234;
        tick();
        m_r_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("drain_sunk_i", i_resp_valid, 1'b0);
            chk1("drain_sunk_d", d_resp_valid, 1'b0);
            chk1("drain_idle_r_ready", m_r_ready, 1'b0);
            tick();
        end
        run_txn(1'b0, 1'b0, 64'h8000_6000, 64'h77, 2'b00, 64'h77, 1'b0);

        // beat arriving on the timeout cycle wins, no orphan
        to_data(1'b0, 64'h8000_6100);
        for (int k = 0; k < TO - 1; k++) tick();
        m_r_valid = 1'b1; m_r_data = 64'h55; m_r_resp = 2'b00;
        tick();
        m_r_valid = 1'b0;
        #1;
        chk1("edge_resp_valid", i_resp_valid, 1'b1);
        chk64("edge_resp_data", i_resp_data, 64'h55);
        chk1("edge_resp_err", i_resp_err, 1'b0);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        #1;
        chk1("edge_no_drain", m_r_ready, 1'b0);

        // flush in DATA: beat consumed, never presented
        to_data(1'b1, 64'h8000_7000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_r_valid = 1'b1; m_r_data = 64'hDEAD;
        tick();
        m_r_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("flush_no_i_resp", i_resp_valid, 1'b0);
            chk1("flush_no_d_resp", d_resp_valid, 1'b0);
            chk1("flush_idle_r_ready", m_r_ready, 1'b0);
            tick();
        end
        run_txn(1'b1, 1'b0, 64'h8000_7100, 64'h99, 2'b00, 64'h99, 1'b0);

        // flush in RESP withdraws resp_valid the next cycle
        to_data(1'b0, 64'h8000_7200);
        m_r_valid = 1'b1; m_r_data = 64'hAB;
        tick();
        m_r_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk1("flush_resp_still", i_resp_valid, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        chk1("flush_resp_drop", i_resp_valid, 1'b0);
        chk1("flush_resp_idle", m_r_ready, 1'b0);

        // flush in IDLE blocks the grant
        i_req_valid = 1'b1; i_req_addr = 64'h8000_7300; flush = 1'b1;
        #1;
        chk1("flush_idle_block", i_req_ready, 1'b0);
        tick();
        i_req_valid = 1'b0; flush = 1'b0;
        #1;
        chk1("flush_idle_no_ar", m_ar_valid, 1'b0);

        // reset in DATA aborts; error response after reset carries data
        to_data(1'b1, 64'h8000_8000);
        rst = 1'b1;
        tick();
        #1;
        chk_all_zero("rst_data");
        rst = 1'b0;
        tick();
        run_txn(1'b0, 1'b1, 64'h8000_8100, 64'hBEEF_0000_1111_2222, 2'b10,
                64'hBEEF_0000_1111_2222, 1'b1);

        // randomized traffic against the transaction-level model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 1'b0; m_lastd = 1'b1; m_cur_d = 1'b0; m_ar_pend = 1'b0;
        m_r_wait = 1'b0; m_rv = 1'b0; i_want = 1'b0; d_want = 1'b0;
        m_cur_addr = 64'h0; mem_addr = 64'h0; ia = 64'h0; da = 64'h0; beat_dly = 0;
        for (int c = 0; c < 3000; c++) begin
            i_req_valid  = i_want;
            i_req_addr   = ia;
            d_req_valid  = d_want;
            d_req_addr   = da;
            m_ar_ready   = 1'($urandom);
            m_r_valid    = m_r_wait && (beat_dly == 0);
            m_r_data     = mem_addr ^ KEY;
            m_r_resp     = {mem_addr[4], 1'b0};
            i_resp_ready = 1'($urandom);
            d_resp_ready = 1'($urandom);
            #1;
            gi = !m_busy && i_want && (!d_want || m_lastd);
            gd = !m_busy && d_want && !gi;
            chk1("rnd_i_req_ready", i_req_ready, gi);
            chk1("rnd_d_req_ready", d_req_ready, gd);
            chk1("rnd_ar_valid", m_ar_valid, m_ar_pend);
            if (m_ar_pend) chk64("rnd_ar_addr", m_ar_addr, m_cur_addr);
            chk1("rnd_r_ready", m_r_ready, m_r_wait);
            chk1("rnd_i_resp_valid", i_resp_valid, m_rv && !m_cur_d);
            chk1("rnd_d_resp_valid", d_resp_valid, m_rv && m_cur_d);
            if (m_rv) begin
                chk64("rnd_resp_data", m_cur_d ? d_resp_data : i_resp_data, m_cur_addr ^ KEY);
                chk1("rnd_resp_err", m_cur_d ? d_resp_err : i_resp_err, m_cur_addr[4]);
            end
            if (gi || gd) begin
                m_busy = 1'b1; m_cur_d = gd; m_cur_addr = gd ? da : ia;
                m_lastd = gd; m_ar_pend = 1'b1;
                if (gd) d_want = 1'b0;
                else i_want = 1'b0;
            end else if (m_ar_pend) begin
                if (m_ar_ready) begin
                    m_ar_pend = 1'b0; m_r_wait = 1'b1;
                    mem_addr = m_ar_addr; beat_dly = $urandom_range(2, 0);
                end
            end else if (m_r_wait) begin
                if (m_r_valid) begin
                    m_r_wait = 1'b0; m_rv = 1'b1;
                end else begin
                    beat_dly--;
                end
            end else if (m_rv && (m_cur_d ? d_resp_ready : i_resp_ready)) begin
                m_rv = 1'b0; m_busy = 1'b0;
            end
            if (!i_want && !(m_busy && !m_cur_d) && $urandom_range(3, 0) == 0) begin
                i_want = 1'b1; ia = {$urandom, $urandom};
            end
            if (!d_want && !(m_busy && m_cur_d) && $urandom_range(3, 0) == 0) begin
                d_want = 1'b1; da = {$urandom, $urandom};
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
